// File: rtl/vga_timing_gen_if.sv
// Timing bundle between vga_timing_gen and its pixel-generator consumers.
// Latency: none, plain wires.
// Backpressure: none; consumers follow the generator, ce throttles the pixel rate.
interface vga_timing_gen_if #(
   parameter int CNT_W = 13
);
   // pixel advance enable, driven by whoever divides the pixel rate
   logic             ce;
   // current raster position
   logic [CNT_W-1:0] loc_x;
   logic [CNT_W-1:0] loc_y;
   // region flags, syncs and strobes
   logic             in_image;
   logic             in_image_x;
   logic             in_image_y;
   logic             sync_h;
   logic             sync_v;
   logic             line_start;
   logic             frame_start;

   // generator side
   modport master (
      input  ce,
      output loc_x, loc_y,
      output in_image, in_image_x, in_image_y,
      output sync_h, sync_v,
      output line_start, frame_start
   );

   // consumer side (also supplies the pixel enable)
   modport slave (
      output ce,
      input  loc_x, loc_y,
      input  in_image, in_image_x, in_image_y,
      input  sync_h, sync_v,
      input  line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing: position counters, region flags, sync pulses, line/frame strobes.
// Latency: one PIXEL_CLK from ce to outputs; with VGA_TIMING_DELAY_EN flags/syncs trail loc by SYNC_DELAY ce-cycles.
// Backpressure: none; all state holds while ce is low.
module vga_timing_gen #(
   parameter int CNT_W      = 13,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int H_SYNC_POL = 0,
   parameter int V_SYNC_POL = 0,
   parameter int SYNC_DELAY = 2
) (
   input  logic           PIXEL_CLK,
   input  logic           RESET_N,
   vga_timing_gen_if.master tim
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // One spare bit so constants equal to 2^CNT_W (e.g. H_ACTIVE of a full-width
   // line) still compare correctly against the counter.
   typedef logic [CNT_W:0]   wide_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam wide_t HX_LAST  = wide_t'(H_TOTAL - 1);
   localparam wide_t VY_LAST  = wide_t'(V_TOTAL - 1);
   localparam wide_t H_ACT_W  = wide_t'(H_ACTIVE);
   localparam wide_t V_ACT_W  = wide_t'(V_ACTIVE);
   localparam wide_t HS_FIRST = wide_t'(H_ACTIVE + H_FP);
   localparam wide_t HS_LAST  = wide_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam wide_t VS_FIRST = wide_t'(V_ACTIVE + V_FP);
   localparam wide_t VS_LAST  = wide_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Counters sit one step before the origin out of reset.
   localparam cnt_t  HX_RST   = HX_LAST[CNT_W-1:0];
   localparam cnt_t  VY_RST   = VY_LAST[CNT_W-1:0];

   localparam logic  H_POL    = (H_SYNC_POL != 0);
   localparam logic  V_POL    = (V_SYNC_POL != 0);

   // Reject geometries the counters cannot represent.
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2^CNT_W");
   end
   if (SYNC_DELAY < 1 || SYNC_DELAY > 8) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY must be 1..8");
   end
   if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
      $error("vga_timing_gen: sync widths must be at least 1");
   end

   // Everything that may be delayed travels together as one word.
   typedef struct packed {
      logic in_image;
      logic in_image_x;
      logic in_image_y;
      logic sync_h;
      logic sync_v;
      logic line_start;
      logic frame_start;
   } flags_t;

   localparam flags_t FLAGS_IDLE = '{
      in_image:    1'b0,
      in_image_x:  1'b0,
      in_image_y:  1'b0,
      sync_h:      ~H_POL,
      sync_v:      ~V_POL,
      line_start:  1'b0,
      frame_start: 1'b0
   };

   cnt_t   hx_q, vy_q;
   cnt_t   hx_nxt, vy_nxt;
   logic   hx_wrap, vy_wrap;
   cnt_t   loc_x_q, loc_y_q;
   flags_t flags_nxt, flags_q, flags_out;
   logic   win_h, win_v;
   logic   act_x, act_y;

   // Next raster position; the vertical wrap only happens together with the horizontal one.
   always_comb begin
      hx_wrap = ({1'b0, hx_q} == HX_LAST);
      vy_wrap = ({1'b0, vy_q} == VY_LAST);
      hx_nxt  = hx_q;
      vy_nxt  = vy_q;
      if (hx_wrap) begin
         hx_nxt = '0;
         if (vy_wrap) begin
            vy_nxt = '0;
         end else begin
            vy_nxt = vy_q + 1'b1;
         end
      end else begin
         hx_nxt = hx_q + 1'b1;
      end
   end

   // Decode flags for the position about to be presented, so they register alongside it.
   always_comb begin
      act_x     = ({1'b0, hx_nxt} < H_ACT_W);
      act_y     = ({1'b0, vy_nxt} < V_ACT_W);
      win_h     = ({1'b0, hx_nxt} >= HS_FIRST) && ({1'b0, hx_nxt} <= HS_LAST);
      win_v     = ({1'b0, vy_nxt} >= VS_FIRST) && ({1'b0, vy_nxt} <= VS_LAST);
      flags_nxt = FLAGS_IDLE;
      flags_nxt.in_image_x  = act_x;
      flags_nxt.in_image_y  = act_y;
      flags_nxt.in_image    = act_x & act_y;
      flags_nxt.sync_h      = win_h ~^ H_POL;
      flags_nxt.sync_v      = win_v ~^ V_POL;
      flags_nxt.line_start  = (hx_nxt == '0);
      flags_nxt.frame_start = (hx_nxt == '0) && (vy_nxt == '0);
   end

   // Position counters advance one step per ce.
   always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hx_q <= HX_RST;
         vy_q <= VY_RST;
      end else if (tim.ce) begin
         hx_q <= hx_nxt;
         vy_q <= vy_nxt;
      end
   end

   // Output registers: loc reads 0,0 in reset even though the counters sit pre-origin.
   always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         loc_x_q <= '0;
         loc_y_q <= '0;
         flags_q <= FLAGS_IDLE;
      end else if (tim.ce) begin
         loc_x_q <= hx_nxt;
         loc_y_q <= vy_nxt;
         flags_q <= flags_nxt;
      end
   end

`ifdef VGA_TIMING_DELAY_EN
   flags_t dly_q [SYNC_DELAY];

   // Flags/syncs trail loc by SYNC_DELAY pixels to cover downstream pixel-generator latency.
   always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < SYNC_DELAY; i++) begin
            dly_q[i] <= FLAGS_IDLE;
         end
      end else if (tim.ce) begin
         dly_q[0] <= flags_q;
         for (int i = 1; i < SYNC_DELAY; i++) begin
            dly_q[i] <= dly_q[i-1];
         end
      end
   end

   assign flags_out = dly_q[SYNC_DELAY-1];
`else
   assign flags_out = flags_q;
`endif

   assign tim.loc_x       = loc_x_q;
   assign tim.loc_y       = loc_y_q;
   assign tim.in_image    = flags_out.in_image;
   assign tim.in_image_x  = flags_out.in_image_x;
   assign tim.in_image_y  = flags_out.in_image_y;
   assign tim.sync_h      = flags_out.sync_h;
   assign tim.sync_v      = flags_out.sync_v;
   assign tim.line_start  = flags_out.line_start;
   assign tim.frame_start = flags_out.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small 8x6 mode and a 1024-wide mode driven by shared ce/reset.
// Expected state comes from the position count since reset; a monitor compares every cycle.
// Works with or without VGA_TIMING_DELAY_EN (flags then trail loc by SYNC_DELAY).
module tb_vga_timing_gen;

`ifdef VGA_TIMING_DELAY_EN
   localparam int DLY = 2;
`else
   localparam int DLY = 0;
`endif

   typedef struct packed {
      logic [15:0] lx;
      logic [15:0] ly;
      logic [6:0]  fl; // in_image, in_x, in_y, sync_h, sync_v, line_start, frame_start
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n     = 0;       // ce advances accepted since the last reset
   int   checks = 0;
   int   errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   bit   seen_1023 = 0;
   bit   seen_wrap = 0;
   logic [15:0] prev_b_lx = '0;

   always #5 clk = ~clk;

   vga_timing_gen_if #(.CNT_W(4))  ia();
   vga_timing_gen_if #(.CNT_W(10)) ib();

   vga_timing_gen #(
      .CNT_W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .SYNC_DELAY(2)
   ) dut_a (.PIXEL_CLK(clk), .RESET_N(rst_n), .tim(ia));

   vga_timing_gen #(
      .CNT_W(10), .H_ACTIVE(800), .H_FP(64), .H_SYNC(80), .H_BP(80),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_SYNC_POL(0), .V_SYNC_POL(0), .SYNC_DELAY(2)
   ) dut_b (.PIXEL_CLK(clk), .RESET_N(rst_n), .tim(ib));

   // Raster state after n accepted advances, straight from the mode's arithmetic.
   function automatic exp_t model(int cnt, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb, bit hp, bit vp);
      exp_t e;
      int ht, vt, k, x, y;
      bit ix, iy, sh, sv;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      e.lx = (cnt == 0) ? 16'd0 : 16'((cnt - 1) % ht);
      e.ly = (cnt == 0) ? 16'd0 : 16'(((cnt - 1) / ht) % vt);
      k = cnt - DLY;
      if (k <= 0) begin
         e.fl = {1'b0, 1'b0, 1'b0, ~hp, ~vp, 1'b0, 1'b0};
      end else begin
         x  = (k - 1) % ht;
         y  = ((k - 1) / ht) % vt;
         ix = (x < ha);
         iy = (y < va);
         sh = (x >= ha + hf && x <= ha + hf + hs - 1) ? hp : ~hp;
         sv = (y >= va + vf && y <= va + vf + vs - 1) ? vp : ~vp;
         e.fl = {ix & iy, ix, iy, sh, sv, x == 0, x == 0 && y == 0};
      end
      return e;
   endfunction

   function automatic exp_t exp_a(int cnt);
      return model(cnt, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
   endfunction

   function automatic exp_t exp_b(int cnt);
      return model(cnt, 800, 64, 80, 80, 2, 1, 1, 1, 1'b0, 1'b0);
   endfunction

   function automatic exp_t act_a();
      return {16'(ia.loc_x), 16'(ia.loc_y), ia.in_image, ia.in_image_x, ia.in_image_y,
              ia.sync_h, ia.sync_v, ia.line_start, ia.frame_start};
   endfunction

   function automatic exp_t act_b();
      return {16'(ib.loc_x), 16'(ib.loc_y), ib.in_image, ib.in_image_x, ib.in_image_y,
              ib.sync_h, ib.sync_v, ib.line_start, ib.frame_start};
   endfunction

   task automatic compare(input string name, input exp_t act, input exp_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s t=%0t: got loc=(%0d,%0d) flags=%b, expected loc=(%0d,%0d) flags=%b",
                     name, $time, act.lx, act.ly, act.fl, exp.lx, exp.ly, exp.fl);
      end
   endtask

   // One clock: account for the edge, optionally reset, queue the expectation, set next ce.
   task automatic step(input bit ce_next, input bit rst_next);
      @(posedge clk);
      if (rst_n && ia.ce) n++;
      #1;
      if (!rst_next) begin
         rst_n = 1'b0;
         n = 0;
      end else begin
         rst_n = 1'b1;
      end
      qa.push_back(exp_a(n));
      qb.push_back(exp_b(n));
      ia.ce = ce_next;
      ib.ce = ce_next;
   endtask

   // Monitor: outputs are registered, so each falling edge presents one result per DUT.
   always @(negedge clk) begin
      if (qa.size() > 0) compare("scoreboard_a", act_a(), qa.pop_front());
      if (qb.size() > 0) begin
         compare("scoreboard_b", act_b(), qb.pop_front());
         if (ib.loc_x == 10'd1023) seen_1023 = 1;
         if (prev_b_lx == 16'd1023 && ib.loc_x == 10'd0) seen_wrap = 1;
         prev_b_lx = 16'(ib.loc_x);
      end
   end

   initial begin
      ia.ce = 1'b0;
      ib.ce = 1'b0;

      // Held in reset, then released into a free-running ce.
      repeat (4) step(1'b0, 1'b0);
      repeat (1100) step(1'b1, 1'b1);

      // Divided pixel rate: ce 1-of-3, then fully random.
      for (int i = 0; i < 600; i++) step((i % 3) == 2, 1'b1);
      repeat (600) step(1'($urandom_range(0, 1)), 1'b1);

      // Reset mid-frame at small-mode position (3,2): must take effect before the next edge.
      repeat (2) step(1'b0, 1'b0);
      for (int g = 0; g < 100 && n < 19; g++) step(1'b1, 1'b1);
      @(posedge clk);
      if (rst_n && ia.ce) n++;
      #1;
      compare("pre_reset_pos_a", act_a(), exp_a(n));
      compare("pre_reset_pos_b", act_b(), exp_b(n));
      rst_n = 1'b0;
      n = 0;
      #1;
      compare("async_reset_a", act_a(), exp_a(0));
      compare("async_reset_b", act_b(), exp_b(0));
      qa.push_back(exp_a(0));
      qb.push_back(exp_b(0));
      ia.ce = 1'b1;
      ib.ce = 1'b1;
      repeat (2) step(1'b1, 1'b0);
      repeat (120) step(1'b1, 1'b1);

      // Random ce with occasional reset pulses.
      repeat (800) step(1'($urandom_range(0, 2) != 0), $urandom_range(0, 149) != 0);

      repeat (3) step(1'b0, 1'b1);
      for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
      #1;
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
      end
      checks++;
      if (!(seen_1023 && seen_wrap)) begin
         errors++;
         $display("FAIL wide_wrap: got seen_1023=%0d seen_wrap=%0d, expected 1/1", seen_1023, seen_wrap);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed-mode VGA sync generator. It produces pixel/line counters, active-region flags, sync pulses of programmable polarity, and line/frame strobes for any display mode set by parameters. It sits at the head of every video pipeline, clocked by the pixel clock, and feeds pattern and blinken pixel generators. Beyond the previous generation, it adds asynchronous reset, a clock-enable for divided pixel rates, registered outputs, and start-of-line/frame strobes.

## Interface
- CNT_W, 13, width of loc_x/loc_y counters
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, 1 = active-high hsync pulse, 0 = active-low
- V_SYNC_POL, 0, 1 = active-high vsync pulse, 0 = active-low
- SYNC_DELAY, 2, pipeline stages applied by VGA_TIMING_DELAY_EN (1..8)

Ports:
- PIXEL_CLK  in  1  pixel clock, all state on rising edge
- RESET_N  in  1  asynchronous active-low reset
- ce  in  1  pixel advance enable; state holds when low
- loc_x  out  CNT_W  current column, 0..H_TOTAL-1
- loc_y  out  CNT_W  current line, 0..V_TOTAL-1
- in_image  out  1  in_image_x & in_image_y
- in_image_x  out  1  loc_x < H_ACTIVE
- in_image_y  out  1  loc_y < V_ACTIVE
- sync_h  out  1  horizontal sync, polarity per H_SYNC_POL
- sync_v  out  1  vertical sync, polarity per V_SYNC_POL
- line_start  out  1  one-ce-cycle pulse at loc_x == 0
- frame_start  out  1  one-ce-cycle pulse at loc_x == 0 and loc_y == 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default). Both must be ≤ 2^CNT_W.
- Internal counters hx and vy reset to H_TOTAL-1 and V_TOTAL-1, the pre-origin position. The first ce after reset advances to (0,0).
- On each ce, hx increments. At H_TOTAL-1, hx wraps to 0 and vy increments. When vy is also at V_TOTAL-1, vy wraps to 0. Both wraps occur in the same cycle.
- The hsync pulse window is H_ACTIVE+H_FP ≤ x ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751 default). The vsync window is V_ACTIVE+V_FP ≤ y ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491 default). Both bounds are inclusive.
- sync_h = window_h XNOR H_SYNC_POL, so it equals H_SYNC_POL inside the window and ~H_SYNC_POL outside. sync_v follows the same rule with V_SYNC_POL.
- Every output is a register loaded on the ce cycle that produces the new position. All outputs describe that same position.
- line_start and frame_start are high only for the ce-cycle at the qualifying position. They clear on the next ce. If ce is low, they hold.
- vsync edges coincide with the cycle where loc_x returns to 0.

## Timing
- Reset values (RESET_N low, asynchronous):
  - loc_x = 0, loc_y = 0
  - in_image = in_image_x = in_image_y = 0
  - sync_h = ~H_SYNC_POL, sync_v = ~V_SYNC_POL
  - line_start = frame_start = 0
- Latency: one PIXEL_CLK from ce high to updated outputs.
- First ce after reset release: loc = (0,0), in_image = 1, line_start = 1, frame_start = 1.
- ce low: all registers hold, including strobes. No position is skipped or repeated.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the next frame starts cleanly at (0,0).
- Frame period is exactly H_TOTAL*V_TOTAL ce cycles.

## Configuration
- VGA_TIMING_DELAY_EN defined:
  - sync_h, sync_v, in_image, in_image_x, in_image_y, line_start and frame_start pass through a SYNC_DELAY-stage shift register that advances on ce only.
  - loc_x and loc_y are not delayed. They lead the delayed signals by SYNC_DELAY ce-cycles so pixel-generator latency is matched.
  - Delay stages reset to the idle values listed under Timing.
- VGA_TIMING_DELAY_EN undefined: no delay stages; all outputs are aligned, and SYNC_DELAY is ignored.

## Test plan
- Reset release, ce=1 constantly, default mode → loc=(0,0) and frame_start=1 on the first edge; sync_h=1 at x=655, 0 at x=656..751, 1 at x=752; 800 cycles per line; 420000 cycles between frame_start pulses.
- Small mode H 4/1/2/1, V 3/1/1/1, POL=1 → H_TOTAL=8, V_TOTAL=6; sync_h high only at x=5,6; sync_v high only at y=4; in_image high for x<4, y<3; loc_y wraps 5→0 when loc_x wraps 7→0.
- ce toggled 1-of-3 cycles, small mode → outputs change only on ce cycles; each strobe is one ce-cycle wide; frame spans 48 ce cycles.
- RESET_N pulsed low at position (3,2) → outputs immediately at reset values; the first ce after release gives (0,0) with frame_start=1.
- VGA_TIMING_DELAY_EN with SYNC_DELAY=2, small mode → frame_start asserts when loc=(2,0); sync_h high when loc_x = 7 and 0.
- CNT_W=10, 1024-wide total (H 800/64/80/80) → loc_x reaches 1023 then wraps to 0 without overflow glitch.
